// File: rtl/core_pkg.sv
// Shared core definitions: loader FSM states and the halt instruction
// returned for fetches outside the loaded program.
package core_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam logic [6:0]  HALT_OPCODE       = 7'b1111111;
  localparam logic [31:0] DEFAULT_HALT_WORD = {25'd0, HALT_OPCODE};

endpackage

// File: rtl/imem_loader_if.sv
// Load stream, status and fetch channel of the instruction memory.
// The master drives loads and fetches; the slave is the memory block.
interface imem_loader_if #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8
) ();

  logic                 load_start;
  logic                 load_valid;
  logic                 load_ready;
  logic [WIDTH-1:0]     load_data;
  logic                 load_last;
  logic                 load_ovf;
  logic                 busy;
  logic [ADD_WIDTH:0]   prog_len;
  logic                 fetch_req;
  logic [ADD_WIDTH-1:0] fetch_addr;
  logic                 fetch_ready;
  logic                 rsp_valid;
  logic [WIDTH-1:0]     rsp_instr;
  logic                 rsp_oob;

  modport master (
    output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    input  load_ready, load_ovf, busy, prog_len, fetch_ready, rsp_valid,
           rsp_instr, rsp_oob
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
    output load_ready, load_ovf, busy, prog_len, fetch_ready, rsp_valid,
           rsp_instr, rsp_oob
  );

endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with a registered read port; contents are
// never reset. A write cycle leaves the read register untouched.
module imem_ram #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADD_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory filled at runtime over a load stream, with a one-cycle
// fetch port that answers out-of-program addresses with the halt word.
module imem_loader
  import core_pkg::*;
#(
  parameter int               DEPTH     = 256,
  parameter int               WIDTH     = 32,
  parameter int               ADD_WIDTH = 8,
  parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(DEFAULT_HALT_WORD)
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.slave  bus
);

  state_t               state_q, state_d;
  logic [ADD_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADD_WIDTH:0]   prog_len_q, prog_len_d;
  logic                 load_ovf_q, load_ovf_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_oob_q, rsp_oob_d;
  logic                 rsp_seen_q, rsp_seen_d;

  logic                 load_hs;
  logic                 fetch_acc;
  logic                 in_range;
  logic                 ram_en;
  logic [ADD_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]     ram_rdata;

  assign bus.load_ready  = (state_q == LOAD) && !bus.load_start;
  assign bus.fetch_ready = (state_q == RUN)  && !bus.load_start;

  assign load_hs   = bus.load_valid && bus.load_ready;
  assign fetch_acc = bus.fetch_req  && bus.fetch_ready;
  assign in_range  = {1'b0, bus.fetch_addr} < prog_len_q;

  // Loads and fetches are exclusive by state, so they share the RAM port.
  assign ram_en   = load_hs || fetch_acc;
  assign ram_addr = load_hs ? wr_ptr_q : bus.fetch_addr;

  imem_ram #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .ADD_WIDTH(ADD_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (load_hs),
    .addr (ram_addr),
    .wdata(bus.load_data),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    load_ovf_d  = load_ovf_q;
    rsp_valid_d = fetch_acc;
    rsp_oob_d   = rsp_oob_q;
    rsp_seen_d  = rsp_seen_q || fetch_acc;

    if (bus.load_start) begin
      state_d    = LOAD;
      wr_ptr_d   = '0;
      prog_len_d = '0;
      load_ovf_d = 1'b0;
    end else if (load_hs) begin
      wr_ptr_d = wr_ptr_q + ADD_WIDTH'(1);
      if (bus.load_last) begin
        state_d    = RUN;
        prog_len_d = {1'b0, wr_ptr_q} + (ADD_WIDTH+1)'(1);
      end else if (wr_ptr_q == ADD_WIDTH'(DEPTH - 1)) begin
        state_d    = RUN;
        prog_len_d = (ADD_WIDTH+1)'(DEPTH);
        load_ovf_d = 1'b1;
      end
    end

    if (fetch_acc) begin
      rsp_oob_d = !in_range;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      load_ovf_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_oob_q   <= 1'b0;
      rsp_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      load_ovf_q  <= load_ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_oob_q   <= rsp_oob_d;
      rsp_seen_q  <= rsp_seen_d;
    end
  end

  // The RAM read register has no reset, so until the first fetch completes
  // the response word is forced to zero.
  assign bus.rsp_instr = !rsp_seen_q ? '0 : (rsp_oob_q ? HALT_WORD : ram_rdata);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_oob   = rsp_oob_q;
  assign bus.busy      = (state_q == LOAD);
  assign bus.prog_len  = prog_len_q;
  assign bus.load_ovf  = load_ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a program-level model is compared
// every cycle, plus literal checks of the documented scenarios.
module tb_imem_loader;
  import core_pkg::*;

  localparam int DEPTH = 256;
  localparam int WIDTH = 32;
  localparam int AW    = 8;
  localparam logic [31:0] HALT = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.WIDTH(WIDTH), .ADD_WIDTH(AW)) bus ();

  imem_loader #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .ADD_WIDTH(AW),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Program-level model: what the loaded program is and what a fetch returns.
  logic [31:0] m_mem [DEPTH];
  int          m_len   = 0;
  int          m_wr    = 0;
  bit          m_load  = 1'b0;
  bit          m_ovf   = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_oob   = 1'b0;
  logic [31:0] m_instr = '0;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_len = 0; m_wr = 0; m_load = 0; m_ovf = 0;
        m_valid = 0; m_oob = 0; m_instr = '0;
      end else begin
        m_valid = 0;
        if (bus.load_start) begin
          m_load = 1; m_wr = 0; m_len = 0; m_ovf = 0;
        end else if (m_load && bus.load_valid) begin
          m_mem[m_wr] = bus.load_data;
          if (bus.load_last) begin
            m_load = 0; m_len = m_wr + 1;
          end else if (m_wr == DEPTH - 1) begin
            m_load = 0; m_len = DEPTH; m_ovf = 1;
          end
          m_wr++;
        end else if (!m_load && bus.fetch_req) begin
          m_valid = 1;
          if (int'(bus.fetch_addr) < m_len) begin
            m_instr = m_mem[bus.fetch_addr]; m_oob = 0;
          end else begin
            m_instr = HALT; m_oob = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_output("rsp_valid",   bus.rsp_valid,   m_valid);
        check_output("rsp_instr",   bus.rsp_instr,   m_instr);
        check_output("rsp_oob",     bus.rsp_oob,     m_oob);
        check_output("busy",        bus.busy,        m_load);
        check_output("prog_len",    bus.prog_len,    m_len);
        check_output("load_ovf",    bus.load_ovf,    m_ovf);
        check_output("load_ready",  bus.load_ready,  m_load && !bus.load_start);
        check_output("fetch_ready", bus.fetch_ready, !m_load && !bus.load_start);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_idle();
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
    bus.load_last  = 0; bus.fetch_req  = 0; bus.fetch_addr = '0;
  endtask

  task automatic start_load();
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
  endtask

  task automatic load_word(input logic [31:0] data, input bit last);
    bus.load_valid = 1; bus.load_data = data; bus.load_last = last;
    tick();
    bus.load_valid = 0; bus.load_last = 0;
  endtask

  task automatic fetch_one(input logic [AW-1:0] addr, input logic [31:0] exp_instr,
                           input bit exp_oob, input string tag);
    bus.fetch_req = 1; bus.fetch_addr = addr;
    tick();
    bus.fetch_req = 0;
    check_output({tag, "_valid"}, bus.rsp_valid, 1);
    check_output({tag, "_instr"}, bus.rsp_instr, exp_instr);
    check_output({tag, "_oob"},   bus.rsp_oob,   exp_oob);
  endtask

  logic [31:0] prog3 [3] = '{32'h00800093, 32'h00200113, 32'h002081B3};
  logic [31:0] exp4  [4] = '{32'h00800093, 32'h00200113, 32'h002081B3, 32'h0000007F};
  logic [31:0] rnd3  [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
  logic [9:0]  vpat      = 10'b1011001101;

  initial begin
    apply_stimulus_idle();
    #1 rst = 1;
    #12 rst = 0;
    tick();
    tick();

    // Empty program: every fetch halts.
    check_output("reset_prog_len", bus.prog_len, 0);
    fetch_one(8'd0, HALT, 1'b1, "reset_fetch0");

    // Three-word program, then back-to-back fetches 0..3.
    start_load();
    for (int i = 0; i < 3; i++) load_word(prog3[i], i == 2);
    for (int i = 0; i < 4; i++) begin
      bus.fetch_req = 1; bus.fetch_addr = AW'(i);
      tick();
      check_output($sformatf("b2b_instr%0d", i), bus.rsp_instr, exp4[i]);
      check_output($sformatf("b2b_oob%0d", i),   bus.rsp_oob,   i == 3);
    end
    bus.fetch_req = 0;
    check_output("b2b_prog_len", bus.prog_len, 3);

    // load_valid toggling: only handshakes advance the write pointer.
    start_load();
    begin
      int k = 0;
      for (int j = 0; j < 10 && k < 3; j++) begin
        bus.load_valid = vpat[j];
        bus.load_data  = vpat[j] ? rnd3[k] : 32'hDEADBEEF;
        bus.load_last  = vpat[j] && (k == 2);
        tick();
        if (vpat[j]) k++;
      end
      bus.load_valid = 0; bus.load_last = 0;
    end
    check_output("toggle_prog_len", bus.prog_len, 3);
    for (int i = 0; i < 3; i++)
      fetch_one(AW'(i), rnd3[i], 1'b0, $sformatf("toggle_fetch%0d", i));

    // Full-depth stream without load_last overflows.
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      bus.load_valid = 1; bus.load_data = 32'hA5000000 | i; bus.load_last = 0;
      tick();
    end
    bus.load_valid = 0;
    check_output("ovf_flag",     bus.load_ovf, 1);
    check_output("ovf_prog_len", bus.prog_len, 256);
    check_output("ovf_busy",     bus.busy,     0);
    fetch_one(8'd255, 32'hA50000FF, 1'b0, "ovf_fetch255");
    fetch_one(8'd0,   32'hA5000000, 1'b0, "ovf_fetch0");

    // load_start and fetch_req together: the load wins.
    bus.load_start = 1; bus.fetch_req = 1; bus.fetch_addr = 8'd0;
    #1;
    check_output("coinc_fetch_ready", bus.fetch_ready, 0);
    check_output("coinc_load_ready",  bus.load_ready,  0);
    tick();
    bus.load_start = 0; bus.fetch_req = 0;
    check_output("coinc_rsp_valid", bus.rsp_valid, 0);
    check_output("coinc_busy",      bus.busy,      1);
    check_output("coinc_prog_len",  bus.prog_len,  0);
    load_word(32'h12345678, 1'b1);
    fetch_one(8'd0, 32'h12345678, 1'b0, "coinc_fetch0");

    // Reset with a response in flight drops it.
    bus.fetch_req = 1; bus.fetch_addr = 8'd0;
    tick();
    bus.fetch_req = 0;
    check_output("inflight_valid_before", bus.rsp_valid, 1);
    #1 rst = 1;
    #1;
    check_output("inflight_valid_after", bus.rsp_valid, 0);
    #1 rst = 0;
    tick();

    // Reset after two of four load words.
    start_load();
    load_word(32'hCAFE0000, 1'b0);
    load_word(32'hCAFE0001, 1'b0);
    #1 rst = 1;
    #1;
    check_output("midload_busy",     bus.busy,     0);
    check_output("midload_prog_len", bus.prog_len, 0);
    #1 rst = 0;
    tick();
    check_output("midload_ovf", bus.load_ovf, 0);
    fetch_one(8'd0, HALT, 1'b1, "midload_fetch0");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
